// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: performs the dcache access for the EX/MEM record and registers the MEM/WB latch.
// Also owns the sticky processor halt and the access and stall performance counters.
package mem_wb_pkg;

  typedef struct packed {
    logic        RegWrite;
    logic        MemToReg;
    logic        dREN;
    logic        dWEN;
    logic        halt;
    logic [4:0]  wsel;
    logic [31:0] npc;
    logic [31:0] aluOut;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
  } ex_mem_t;

  typedef struct packed {
    logic        RegWrite;
    logic        MemToReg;
    logic        halt;
    logic [4:0]  wsel;
    logic [31:0] npc;
    logic [31:0] aluOut;
    logic [31:0] dmemload;
  } mem_wb_t;

endpackage

module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int HALT_DRAIN = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  ex_mem_t          exmem_i,
  input  logic             exmem_valid,
  input  logic             dhit,
  input  logic [31:0]      dmemload,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic [31:0]      dmemaddr,
  output logic [31:0]      dmemstore,
  output logic             mem_stall,
  output mem_wb_t          memwb_o,
  output logic             halt,
  output logic [CNT_W-1:0] acc_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam int DW = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
  logic              halt_q, halt_d;
  mem_wb_t           memwb_q, memwb_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic              req_ok;
  logic              req_active;
  mem_wb_t           copy_rec;

  // Requests are gated by nRST so they drop the moment reset is asserted.
  always_comb begin
    req_ok     = nRST & exmem_valid & ((state_q == IDLE) | (state_q == ACCESS));
    dmemREN    = req_ok & exmem_i.dREN;
    dmemWEN    = req_ok & exmem_i.dWEN & ~exmem_i.dREN;
    req_active = dmemREN | dmemWEN;
    mem_stall  = req_active & ~dhit;
    dmemaddr   = exmem_i.dmemaddr;
    dmemstore  = exmem_i.dmemstore;
  end

  always_comb begin
    copy_rec          = '0;
    copy_rec.RegWrite = exmem_i.RegWrite;
    copy_rec.MemToReg = exmem_i.MemToReg;
    copy_rec.halt     = exmem_i.halt;
    copy_rec.wsel     = exmem_i.wsel;
    copy_rec.npc      = exmem_i.npc;
    copy_rec.aluOut   = exmem_i.aluOut;
    copy_rec.dmemload = exmem_i.dREN ? dmemload : 32'd0;
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    halt_d      = halt_q;
    memwb_d     = memwb_q;
    unique case (state_q)
      IDLE, ACCESS: begin
        if (mem_stall) begin
          memwb_d = '0;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
          if (exmem_valid) begin
            memwb_d = copy_rec;
            // A halt record leaves this stage only once its own access (if any) is done.
            if (exmem_i.halt) begin
              drain_cnt_d = '0;
              if (HALT_DRAIN == 0) begin
                state_d = HALTED;
                halt_d  = 1'b1;
              end else begin
                state_d = DRAIN;
              end
            end
          end else begin
            memwb_d = '0;
          end
        end
      end
      DRAIN: begin
        memwb_d = '0;
        if (drain_cnt_q == DW'(HALT_DRAIN - 1)) begin
          state_d = HALTED;
          halt_d  = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters saturate; in HALTED no request or stall exists, so they freeze naturally.
  always_comb begin
    acc_d   = acc_q;
    stall_d = stall_q;
    if (req_active && dhit && (acc_q != {CNT_W{1'b1}}))
      acc_d = acc_q + 1'b1;
    if (mem_stall && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      halt_q      <= 1'b0;
      memwb_q     <= '0;
      acc_q       <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halt_q      <= halt_d;
      memwb_q     <= memwb_d;
      acc_q       <= acc_d;
      stall_q     <= stall_d;
    end
  end

  assign memwb_o     = memwb_q;
  assign halt        = halt_q;
  assign acc_count   = acc_q;
  assign stall_count = stall_q;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer end of the EX/MEM pipeline latch and producer of the MEM/WB latch in the 5-stage MIPS pipeline.
- Takes an ex_mem_t record and performs the data-memory access through the dcache request/hit handshake.
- Stalls upstream until dhit, then registers a mem_wb_t record for writeback.
- Owns the sticky processor halt and two performance counters: access count and stall-cycle count.

Parameters:
CNT_W, 32, width of the performance counters; counters saturate at all-ones.
HALT_DRAIN, 1, cycles spent in DRAIN after a halt record is accepted, before halt asserts.

Ports:
CLK  input  1  system clock, rising edge.
nRST  input  1  asynchronous active-low reset.
exmem_i  input  $bits(ex_mem_t)  EX/MEM latch contents.
exmem_valid  input  1  exmem_i holds a real instruction; 0 means a bubble.
dhit  input  1  dcache access complete; dmemload is valid when reading.
dmemload  input  32  read data from the dcache.
dmemREN  output  1  dcache read request.
dmemWEN  output  1  dcache write request.
dmemaddr  output  32  equals exmem_i.dmemaddr.
dmemstore  output  32  equals exmem_i.dmemstore.
mem_stall  output  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle.
memwb_o  output  $bits(mem_wb_t)  registered MEM/WB latch.
halt  output  1  sticky processor halt.
acc_count  output  CNT_W  number of completed memory accesses.
stall_count  output  CNT_W  number of cycles with mem_stall high.

Behaviour:
- Reset (async, nRST low): memwb_o all zeros, halt=0, both counters 0, state IDLE. Requests deassert immediately. An access in flight is abandoned; no completion is recorded.
- States: IDLE, ACCESS, DRAIN, HALTED.
- Request generation (combinational):
  - req_ok = exmem_valid & (state is IDLE or ACCESS).
  - dmemREN = req_ok & exmem_i.dREN.
  - dmemWEN = req_ok & exmem_i.dWEN & ~exmem_i.dREN. If both dREN and dWEN are set, the access is a read.
- mem_stall = (dmemREN | dmemWEN) & ~dhit. A same-cycle dhit gives zero stall cycles.
- State transitions:
  - IDLE -> ACCESS when a request is raised without dhit.
  - ACCESS -> IDLE on dhit.
  - Requests and address stay asserted and stable while in ACCESS (upstream is held). A dhit arriving when no request is active is ignored.
- Latch update each cycle when not in HALTED:
  - mem_stall=1: memwb_o loads a bubble (all zeros: RegWrite=0, halt=0).
  - mem_stall=0 and exmem_valid=1: memwb_o copies every field ex_mem_t shares with mem_wb_t. dmemload = dmemload input on a read, else 0.
  - mem_stall=0 and exmem_valid=0: memwb_o loads a bubble.
- Halt:
  - Trigger: exmem_valid & exmem_i.halt with mem_stall=0. The record is latched with halt=1 and the state goes to DRAIN.
  - DRAIN: memwb_o loads bubbles, and no requests are issued even if exmem_valid is high.
  - After HALT_DRAIN cycles in DRAIN: state HALTED and halt=1.
  - HALTED: terminal until reset. memwb_o holds, requests stay 0, mem_stall=0.
  - A halt record that also carries dREN or dWEN completes its access first.
- Counters:
  - acc_count increments on each cycle where a request is active and dhit=1.
  - stall_count increments on each cycle where mem_stall=1.
  - Both saturate and never wrap. Both freeze in HALTED.

Test Plan:
1. Reset: nRST low mid-run -> memwb_o=0, halt=0, dmemREN=dmemWEN=0, acc_count=stall_count=0 asynchronously.
2. lw addr 0x100, dhit after 3 cycles with dmemload=0xDEADBEEF:
   - dmemREN high for 4 cycles; mem_stall high for 3.
   - memwb_o takes 3 bubbles, then dmemload=0xDEADBEEF with RegWrite=1.
   - stall_count=3, acc_count=1.
3. sw addr 0x200 data 0x12345678 with same-cycle dhit -> dmemWEN for 1 cycle, dmemstore=0x12345678, mem_stall never asserts, acc_count=1.
4. Back-to-back ALU records (dREN=dWEN=0) -> no requests, one memwb_o update per cycle with aluOut passed through, counters unchanged.
5. halt record after a lw:
   - lw completes first.
   - halt=1 exactly HALT_DRAIN+1 cycles after the halt record is accepted.
   - A subsequent valid sw issues no dmemWEN; counters frozen.
6. nRST pulsed during ACCESS (dhit not yet seen) -> request drops immediately, acc_count stays 0, memwb_o=0; after release, a fresh lw completes normally.
